// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the wide-operation sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// Runs 2*DATA_WIDTH-bit AND/OR/ADD/SUB/SLT as 2-3 passes through one narrow ALU.
// Optional macro ALU_SEQ_PERF_CNT_EN adds perf_alu_cycles (cycles spent in LO/HI/FIX).
module alu_wide_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [2*DATA_WIDTH-1:0] resp_result,
  output logic                    resp_carryout,
  output logic                    resp_overflow,
  output logic                    resp_zero,
`ifdef ALU_SEQ_PERF_CNT_EN
  output logic [31:0]             perf_alu_cycles,
`endif
  output logic [DATA_WIDTH-1:0]   alu_A,
  output logic [DATA_WIDTH-1:0]   alu_B,
  output logic [2:0]              alu_ALUop,
  input  logic [DATA_WIDTH-1:0]   alu_Result,
  input  logic                    alu_CarryOut,
  input  logic                    alu_Overflow,
  input  logic                    alu_Zero
);

  localparam int W2 = 2 * DATA_WIDTH;

  state_t                  state_q, state_d;
  logic [2:0]              op_q;
  logic [W2-1:0]           a_q, b_q;
  logic [DATA_WIDTH-1:0]   r_lo, r_hi;
  logic                    c0, c1, c2;
  logic                    is_sub, need_fix;
  logic [2:0]              pass_op;
  logic [W2-1:0]           full, fin_result;
  logic                    fin_carry, fin_ovf;
  logic                    unused_alu_flags;

  // Flags are rebuilt from the 64-bit result, so the ALU's own ovf/zero go unused.
  assign unused_alu_flags = alu_Overflow ^ alu_Zero;

  assign is_sub   = (op_q == ALU_SUB) || (op_q == ALU_SLT);
  assign need_fix = ((op_q == ALU_ADD) && c0) || (is_sub && !c0);
  assign pass_op  = (op_q == ALU_SLT) ? ALU_SUB : op_q;
  assign req_ready = (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUop = '0;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = is_legal_op(req_op) ? ST_LO : ST_DONE;
      ST_LO: begin
        alu_A     = a_q[DATA_WIDTH-1:0];
        alu_B     = b_q[DATA_WIDTH-1:0];
        alu_ALUop = pass_op;
        state_d   = ST_HI;
      end
      ST_HI: begin
        alu_A     = a_q[W2-1:DATA_WIDTH];
        alu_B     = b_q[W2-1:DATA_WIDTH];
        alu_ALUop = pass_op;
        state_d   = need_fix ? ST_FIX : ST_DONE;
      end
      // Propagate the low-half carry/borrow into the high word: t+1 or t-1.
      ST_FIX: begin
        alu_A     = r_hi;
        alu_B     = DATA_WIDTH'(1);
        alu_ALUop = (op_q == ALU_ADD) ? ALU_ADD : ALU_SUB;
        state_d   = ST_DONE;
      end
      ST_DONE: if (resp_valid && resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    full       = {r_hi, r_lo};
    fin_result = '0;
    fin_carry  = 1'b0;
    fin_ovf    = 1'b0;
    case (op_q)
      ALU_AND, ALU_OR: fin_result = full;
      ALU_ADD: begin
        fin_result = full;
        fin_carry  = c1 | c2;
        fin_ovf    = (a_q[W2-1] == b_q[W2-1]) && (full[W2-1] != a_q[W2-1]);
      end
      ALU_SUB, ALU_SLT: begin
        fin_carry  = c1 & c2;
        fin_ovf    = (a_q[W2-1] != b_q[W2-1]) && (full[W2-1] != a_q[W2-1]);
        fin_result = (op_q == ALU_SUB) ? full
                                       : {{(W2-1){1'b0}}, full[W2-1] ^ fin_ovf};
      end
      default: fin_result = '0;
    endcase
  end

  // DONE spends one cycle registering the final result before resp_valid rises.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      r_lo          <= '0;
      r_hi          <= '0;
      c0            <= 1'b0;
      c1            <= 1'b0;
      c2            <= 1'b0;
      resp_valid    <= 1'b0;
      resp_result   <= '0;
      resp_carryout <= 1'b0;
      resp_overflow <= 1'b0;
      resp_zero     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          op_q <= req_op;
          a_q  <= req_a;
          b_q  <= req_b;
        end
        ST_LO: begin
          r_lo <= alu_Result;
          c0   <= alu_CarryOut;
        end
        ST_HI: begin
          r_hi <= alu_Result;
          c1   <= alu_CarryOut;
          c2   <= is_sub;
        end
        ST_FIX: begin
          r_hi <= alu_Result;
          c2   <= alu_CarryOut;
        end
        ST_DONE: begin
          if (!resp_valid) begin
            resp_valid    <= 1'b1;
            resp_result   <= fin_result;
            resp_carryout <= fin_carry;
            resp_overflow <= fin_ovf;
            resp_zero     <= (fin_result == '0);
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      perf_alu_cycles <= '0;
    else if ((state_q == ST_LO) || (state_q == ST_HI) || (state_q == ST_FIX))
      perf_alu_cycles <= perf_alu_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_wide_seq.sv
// Scoreboard bench for alu_wide_seq paired with a behavioural 32-bit ALU.
// Expected responses come from plain 64-bit arithmetic on the request operands.
module tb_alu_wide_seq;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int W2 = 64;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [W2-1:0] req_a, req_b;
  logic          resp_valid, resp_ready;
  logic [W2-1:0] resp_result;
  logic          resp_carryout, resp_overflow, resp_zero;
  logic [DW-1:0] alu_A, alu_B, alu_Result;
  logic [2:0]    alu_ALUop;
  logic          alu_CarryOut, alu_Overflow, alu_Zero;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [31:0]   perf_alu_cycles;
`endif

  always #5 clk = ~clk;

  alu_wide_seq #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_carryout(resp_carryout), .resp_overflow(resp_overflow), .resp_zero(resp_zero),
`ifdef ALU_SEQ_PERF_CNT_EN
    .perf_alu_cycles(perf_alu_cycles),
`endif
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_CarryOut(alu_CarryOut),
    .alu_Overflow(alu_Overflow), .alu_Zero(alu_Zero)
  );

  // Stand-in for the existing combinational 32-bit ALU.
  logic [DW:0] alu_sum;
  always_comb begin
    alu_sum      = '0;
    alu_Result   = '0;
    alu_CarryOut = 1'b0;
    alu_Overflow = 1'b0;
    case (alu_ALUop)
      ALU_AND: alu_Result = alu_A & alu_B;
      ALU_OR:  alu_Result = alu_A | alu_B;
      ALU_ADD: begin
        alu_sum      = {1'b0, alu_A} + {1'b0, alu_B};
        alu_Result   = alu_sum[DW-1:0];
        alu_CarryOut = alu_sum[DW];
        alu_Overflow = (alu_A[DW-1] == alu_B[DW-1]) && (alu_Result[DW-1] != alu_A[DW-1]);
      end
      ALU_SUB: begin
        alu_sum      = {1'b0, alu_A} + {1'b0, ~alu_B} + 33'd1;
        alu_Result   = alu_sum[DW-1:0];
        alu_CarryOut = alu_sum[DW];
        alu_Overflow = (alu_A[DW-1] != alu_B[DW-1]) && (alu_Result[DW-1] != alu_A[DW-1]);
      end
      ALU_SLT: alu_Result = {31'b0, $signed(alu_A) < $signed(alu_B)};
      default: alu_Result = '0;
    endcase
    alu_Zero = (alu_Result == '0);
  end

  typedef struct {
    logic [W2-1:0] res;
    logic          c;
    logic          v;
    logic          z;
    int            lat;
    int            e0;
  } exp_t;

  exp_t        sbq[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int unsigned cycle       = 0;
  int          lastHsEdge  = -10;
  int          readyMode   = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [W2-1:0] actual,
                             input logic [W2-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic exp_t refModel(input logic [2:0] op, input logic [W2-1:0] a,
                                    input logic [W2-1:0] b);
    exp_t          e;
    logic [W2:0]   s;
    logic [32:0]   lo;
    logic [W2-1:0] d;
    e = '{res: '0, c: 1'b0, v: 1'b0, z: 1'b0, lat: 3, e0: 0};
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[W2-1:0];
        e.c   = s[W2];
        e.v   = (a[63] == b[63]) && (e.res[63] != a[63]);
        lo    = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        if (lo[32]) e.lat = 4;
      end
      3'b110, 3'b111: begin
        d   = a - b;
        e.c = (a >= b);
        e.v = (a[63] != b[63]) && (d[63] != a[63]);
        if (a[31:0] < b[31:0]) e.lat = 4;
        e.res = (op == 3'b110) ? d : {63'b0, $signed(a) < $signed(b)};
      end
      default: begin
        e.res = '0;
        e.lat = 1;
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [W2-1:0] a,
                               input logic [W2-1:0] b, input bit keep, input bit b2b);
    exp_t e;
    int   waited;
    e         = refModel(op, a, b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waited++;
      if (waited > 300) begin
        checkOutput("accept_timeout", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b0;
        return;
      end
    end
    e.e0 = int'(cycle) + 1;
    if (b2b) checkOutput("back_to_back_accept", 64'(e.e0), 64'(lastHsEdge + 1));
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = ($urandom_range(0, 3) != 0);
        default: resp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on the rising edge of resp_valid, stability while stalled,
  // quiet ALU port while a response is pending, and payload on handshake.
  initial begin
    exp_t          e;
    logic          prevValid, stallPrev;
    logic [W2-1:0] snapRes;
    logic [2:0]    snapFlags;
    prevValid = 1'b0;
    stallPrev = 1'b0;
    snapRes   = '0;
    snapFlags = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prevValid = 1'b0;
        stallPrev = 1'b0;
        continue;
      end
      if (resp_valid && !prevValid) begin
        if (sbq.size() == 0) checkOutput("unexpected_resp", {63'b0, resp_valid}, 64'd0);
        else checkOutput("latency", 64'(int'(cycle) - sbq[0].e0), 64'(sbq[0].lat));
      end
      if (resp_valid) begin
        checkOutput("alu_quiet", {29'b0, alu_ALUop, alu_A}, 64'd0);
        checkOutput("alu_quiet_b", {32'b0, alu_B}, 64'd0);
        checkOutput("req_ready_busy", {63'b0, req_ready}, 64'd0);
      end
      if (resp_valid && stallPrev) begin
        checkOutput("stall_result", resp_result, snapRes);
        checkOutput("stall_flags", {61'b0, resp_carryout, resp_overflow, resp_zero},
                    {61'b0, snapFlags});
      end
      if (resp_valid && resp_ready && sbq.size() != 0) begin
        e = sbq.pop_front();
        checkOutput("result", resp_result, e.res);
        checkOutput("carryout", {63'b0, resp_carryout}, {63'b0, e.c});
        checkOutput("overflow", {63'b0, resp_overflow}, {63'b0, e.v});
        checkOutput("zero", {63'b0, resp_zero}, {63'b0, e.z});
        lastHsEdge = int'(cycle) + 1;
      end
      stallPrev = resp_valid && !resp_ready;
      snapRes   = resp_result;
      snapFlags = {resp_carryout, resp_overflow, resp_zero};
      prevValid = resp_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic [2:0]  opTable[8];
  logic [31:0] edgeVals[6];

  initial begin
    logic [2:0]    op;
    logic [31:0]   h[4];
    bit            keep, prevKeep;
    int            waited;
    opTable  = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b010, 3'b110, 3'b011};
    edgeVals = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h0};
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_resp_valid", {63'b0, resp_valid}, 64'd0);
    checkOutput("reset_req_ready", {63'b0, req_ready}, 64'd1);
    checkOutput("reset_result", resp_result, 64'd0);
    checkOutput("reset_flags", {61'b0, resp_carryout, resp_overflow, resp_zero}, 64'd0);
    checkOutput("reset_alu", {29'b0, alu_ALUop, alu_A}, 64'd0);
    resetn = 1'b1;

    $display("[TB] directed vectors");
    readyMode = 0;
    applyStimulus(3'b010, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0);
    applyStimulus(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
    applyStimulus(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
    applyStimulus(3'b110, 64'h0000_0001_0000_0000, 64'd1, 0, 0);
    applyStimulus(3'b110, 64'd0, 64'd1, 0, 0);
    applyStimulus(3'b111, 64'h8000_0000_0000_0000, 64'd1, 0, 0);
    applyStimulus(3'b111, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    applyStimulus(3'b000, 64'hF0F0_0000_0000_00FF, 64'h00FF_0000_0000_000F, 0, 0);
    applyStimulus(3'b011, 64'h1234, 64'h5678, 0, 0);
    waitDrain();

    $display("[TB] backpressure");
    readyMode = 2;
    applyStimulus(3'b110, 64'h0000_0005_0000_0000, 64'd7, 0, 0);
    waited = 0;
    while (!resp_valid && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("bp_resp_valid", {63'b0, resp_valid}, 64'd1);
    repeat (5) @(posedge clk);
    readyMode = 0;
    waitDrain();

    $display("[TB] back-to-back");
    applyStimulus(3'b010, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF, 1, 0);
    applyStimulus(3'b001, 64'hAAAA_0000_5555_0000, 64'h0000_AAAA_0000_5555, 1, 1);
    applyStimulus(3'b101, 64'd9, 64'd3, 1, 1);
    applyStimulus(3'b111, 64'd3, 64'd9, 0, 1);
    waitDrain();

    $display("[TB] reset during HI");
    req_op    = 3'b110;
    req_a     = 64'h0000_0001_0000_0000;
    req_b     = 64'd1;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_resp_valid", {63'b0, resp_valid}, 64'd0);
    checkOutput("abort_req_ready", {63'b0, req_ready}, 64'd1);
    checkOutput("abort_alu", {29'b0, alu_ALUop, alu_A}, 64'd0);
    resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort_no_resp", {63'b0, resp_valid}, 64'd0);

    $display("[TB] random stream");
    readyMode = 1;
    prevKeep  = 1'b0;
    for (int n = 0; n < 60; n++) begin
      op = opTable[$urandom_range(0, 7)];
      for (int k = 0; k < 4; k++)
        h[k] = ($urandom_range(0, 2) == 0) ? edgeVals[$urandom_range(0, 4)] : $urandom;
      keep = ($urandom_range(0, 1) == 1) && (n != 59);
      applyStimulus(op, {h[0], h[1]}, {h[2], h[3]}, keep, prevKeep);
      prevKeep = keep;
    end
    readyMode = 0;
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
